ftdi_chn_sched: RTL

Channel scheduler for the FT60x master FIFO bus in 600 (multi-channel) mode; also usable in 245 mode.
Takes the slave per-channel status snapshot from the status phase, host enables and internal FIFO levels, and picks one channel plus one direction per bus tenure using round-robin.
Enforces a per-grant beat quota so that one channel cannot hog the bus.
The master FSM consumes gnt_* in place of a free-running channel counter and reports beats and end of transfer back.

---
 rtl/ftdi_chn_sched_if.sv | 17 +
 rtl/ftdi_chn_sched.sv | 101 ++++++++++
 2 files changed

// File: rtl/ftdi_chn_sched_if.sv
// ftdi_chn_sched_if: grant handshake between the channel scheduler and the master FIFO FSM
interface ftdi_chn_sched_if #(
    parameter int CNT_CHANNLS = 4,
    parameter int QUOTA_W     = 8
);
    localparam int CW = $clog2(CNT_CHANNLS);
    logic               gnt_vld;
    logic [CW-1:0]      gnt_chn;
    logic               gnt_dir;
    logic               gnt_stop;
    logic [QUOTA_W-1:0] beat_cnt;
    logic               busy;
    logic               beat;
    logic               xfer_end;
    modport master (input gnt_vld, gnt_chn, gnt_dir, gnt_stop, beat_cnt, busy, output beat, xfer_end);
    modport slave (output gnt_vld, gnt_chn, gnt_dir, gnt_stop, beat_cnt, busy, input beat, xfer_end);
endinterface

// File: rtl/ftdi_chn_sched.sv
// ftdi_chn_sched: round-robin channel/direction scheduler with per-grant beat quota for the FT60x bus
module ftdi_chn_sched #(
    parameter int CNT_CHANNLS        = 4,
    parameter int CNT_CODE_NUM_CHNLS = $clog2(CNT_CHANNLS),
    parameter int QUOTA_W            = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mltcn,
    input  logic                   st_vld,
    input  logic [CNT_CHANNLS-1:0] st_rxf_n,
    input  logic [CNT_CHANNLS-1:0] st_txe_n,
    input  logic [CNT_CHANNLS-1:0] mst_rd_en,
    input  logic [CNT_CHANNLS-1:0] mst_wr_en,
    input  logic [CNT_CHANNLS-1:0] ibuf_afull,
    input  logic [CNT_CHANNLS-1:0] ibuf_nempt,
    input  logic                   stren,
    input  logic [QUOTA_W-1:0]     quota,
    ftdi_chn_sched_if.slave        gif
);
    typedef enum logic [1:0] {IDLE, ARB, GRANT, DRAIN} state_t;
    state_t                        state;
    logic [CNT_CODE_NUM_CHNLS-1:0] ptr, win_ch, idx;
    logic [CNT_CHANNLS-1:0]        dir_last, snap_rxf_n, snap_txe_n, mask, rd_el, wr_el, el;
    logic                          win, win_dir, reach;
    logic [QUOTA_W:0]              cnt_nxt, target;

    assign mask    = mltcn ? '1 : CNT_CHANNLS'(1);
    assign rd_el   = mst_rd_en & ~snap_rxf_n & ~ibuf_afull & mask;
    assign wr_el   = mst_wr_en & ~snap_txe_n & (ibuf_nempt | {CNT_CHANNLS{stren}}) & mask;
    assign el      = rd_el | wr_el;
    assign win_dir = (rd_el[win_ch] & wr_el[win_ch]) ? ~dir_last[win_ch] : wr_el[win_ch];
    assign cnt_nxt = {1'b0, gif.beat_cnt} + 1'b1;
    assign target  = (quota == '0) ? {1'b1, {QUOTA_W{1'b0}}} : {1'b0, quota};
    assign reach   = gif.beat & (cnt_nxt == target);
    assign gif.busy = state != IDLE;

    // first eligible channel after ptr; descending scan so the nearest one is assigned last
    always_comb begin
        win    = 1'b0;
        win_ch = '0;
        idx    = '0;
        for (int k = CNT_CHANNLS; k >= 1; k--) begin
            idx = CNT_CODE_NUM_CHNLS'((int'(ptr) + k) % CNT_CHANNLS);
            if (el[idx]) begin
                win    = 1'b1;
                win_ch = idx;
            end
        end
    end

    // scheduler FSM: snapshot, one-cycle arbitration, grant with quota, drain of late beats
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= CNT_CODE_NUM_CHNLS'(CNT_CHANNLS - 1);
            dir_last     <= '0;
            snap_rxf_n   <= '1;
            snap_txe_n   <= '1;
            gif.gnt_vld  <= 1'b0;
            gif.gnt_chn  <= '0;
            gif.gnt_dir  <= 1'b0;
            gif.gnt_stop <= 1'b0;
            gif.beat_cnt <= '0;
        end else begin
            gif.gnt_stop <= 1'b0;
            case (state)
                IDLE: begin
                    if (st_vld) begin
                        snap_rxf_n <= st_rxf_n;
                        snap_txe_n <= st_txe_n;
                        state      <= ARB;
                    end
                end
                ARB: begin
                    state <= win ? GRANT : IDLE;
                    if (win) begin
                        gif.gnt_vld      <= 1'b1;
                        gif.gnt_chn      <= win_ch;
                        gif.gnt_dir      <= win_dir;
                        gif.beat_cnt     <= '0;
                        ptr              <= win_ch;
                        dir_last[win_ch] <= win_dir;
                    end
                end
                GRANT, DRAIN: begin
                    if (gif.beat && !(&gif.beat_cnt))
                        gif.beat_cnt <= gif.beat_cnt + 1'b1;
                    if (gif.xfer_end) begin
                        state       <= IDLE;
                        gif.gnt_vld <= 1'b0;
                    end else if (state == GRANT && reach) begin
                        state        <= DRAIN;
                        gif.gnt_stop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
